// File: rtl/imem_arb_pkg.sv
// ============================================================================
// Module : imem_arb_pkg
// Brief  : Shared state encoding and default sizes for the imem load arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int c_addr_w     = 14;
    localparam int c_data_w     = 32;
    localparam int c_rst_cycles = 4;

endpackage

`default_nettype wire

// File: rtl/imem_rst_stretch.sv
// ============================================================================
// Module : imem_rst_stretch
// Brief  : Loadable down-counter; holds cpu_rst for RST_CYCLES cycles and
//          strobes done in the final one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_rst_stretch #(
    parameter int RST_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic active,
    output logic done
);

    localparam logic [7:0] c_load = 8'(RST_CYCLES);

    logic [7:0] r_cnt;
    logic       r_active;

    assign done   = (r_cnt == 8'd1);
    assign active = r_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 8'd0;
            r_active <= 1'b0;
        end else if (start) begin
            r_cnt    <= c_load;
            r_active <= 1'b1;
        end else if (r_cnt != 8'd0) begin
            r_cnt    <= r_cnt - 8'd1;
            r_active <= ~done;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_load_arbiter.sv
// ============================================================================
// Module : imem_load_arbiter
// Brief  : Shares the instruction-memory port between CPU fetch and a serial
//          program loader. Optional IMEM_LOAD_CHECKSUM_EN adds a word sum.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_load_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w,
    parameter int DATA_W     = c_data_w,
    parameter int MAX_WORDS  = 16384,
    parameter int RST_CYCLES = c_rst_cycles
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic [31:0]       ld_checksum,
    output logic              busy
);

    localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(MAX_WORDS - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_hold_addr;
    logic              r_cpu_hold;
    logic              w_wr;
    logic              w_last;
    logic              w_rst_start;
    logic              w_rst_done;

    assign w_wr        = (r_state == ST_LOAD) && ld_valid;
    assign w_last      = w_wr && (r_count == c_last_idx);
    assign w_rst_start = (r_state == ST_LOAD) && (w_next == ST_RELEASE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RUN:     if (ld_start) w_next = ST_DRAIN;
            ST_DRAIN:   w_next = ST_LOAD;
            ST_LOAD:    if (ld_done || w_last) w_next = ST_RELEASE;
            ST_RELEASE: if (w_rst_done) w_next = ST_RUN;
            default:    w_next = ST_RUN;
        endcase
    end

    // DRAIN keeps the last fetch address so the in-flight read completes.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = 1'b0;
        ld_ready  = 1'b0;
        mem_wdata = ld_data;
        case (r_state)
            ST_DRAIN: mem_addr = r_hold_addr;
            ST_LOAD: begin
                ld_ready = 1'b1;
                mem_we   = ld_valid;
                mem_addr = r_count[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cpu_hold  <= 1'b0;
            r_count     <= '0;
            r_hold_addr <= '0;
        end else begin
            r_cpu_hold <= (w_next != ST_RUN);
            if (r_state == ST_RUN) begin
                r_hold_addr <= cpu_addr;
            end
            if (r_state == ST_DRAIN) begin
                r_count <= '0;
            end else if (w_wr) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sum <= 32'd0;
        end else if (r_state == ST_DRAIN) begin
            r_sum <= 32'd0;
        end else if (w_wr) begin
            r_sum <= r_sum + 32'(ld_data);
        end
    end

    assign ld_checksum = r_sum;
`else
    assign ld_checksum = 32'd0;
`endif

    imem_rst_stretch #(
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_stretch (
        .clk    (clock),
        .rst    (reset),
        .start  (w_rst_start),
        .active (cpu_rst),
        .done   (w_rst_done)
    );

    assign cpu_instr = mem_rdata;
    assign cpu_hold  = r_cpu_hold;
    assign busy      = (r_state != ST_RUN);
    assign ld_count  = r_count;

endmodule

`default_nettype wire

// File: doc/imem_load_arbiter.md
Name: imem_load_arbiter

Overview:
Arbitrates the single port of the instruction memory between the CPU fetch path and a serial program loader. In normal operation the fetch path owns the memory. On a load request, the block freezes the PC, lets any in-flight synchronous read finish, and streams loader words into consecutive word addresses. It then holds the CPU in reset for a fixed number of cycles so execution restarts at PC 0 with the new image. It sits between the fetch unit, the loader front end and the instruction-memory macro.

Parameters:
ADDR_W, 14, word-address width of the instruction memory (64KB / 4).
DATA_W, 32, instruction word width.
MAX_WORDS, 16384, capacity in words; the load ends automatically after this many writes.
RST_CYCLES, 4, number of cycles cpu_rst is held after a load; legal range 1..255.

Ports:
clock  in  1  system clock; all state changes on posedge.
reset  in  1  asynchronous, active-high reset.
cpu_addr  in  ADDR_W  fetch word address (PC[15:2]).
cpu_instr  out  DATA_W  instruction returned to fetch (mem_rdata passthrough).
cpu_hold  out  1  registered; 1 = PC must not update.
cpu_rst  out  1  registered; 1 = fetch/PC forced to reset.
mem_addr  out  ADDR_W  memory address.
mem_we  out  1  memory write enable.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr.
ld_start  in  1  load request, sampled in RUN only.
ld_valid  in  1  loader word valid.
ld_data  in  DATA_W  loader word.
ld_ready  out  1  block accepts a word this cycle.
ld_done  in  1  loader end-of-image, level or pulse.
ld_count  out  ADDR_W+1  words written in the current or last load.
ld_checksum  out  32  see Optional Feature.
busy  out  1  1 in any state other than RUN.

Behaviour:
- States are RUN, DRAIN, LOAD, RELEASE.
- Reset (asynchronous) puts the block in RUN with:
  - cpu_hold=0, cpu_rst=0, ld_ready=0, busy=0, mem_we=0.
  - ld_count=0, write pointer=0, release counter=0, checksum=0.
- RUN:
  - mem_addr=cpu_addr, mem_we=0.
  - ld_start=1 moves the block to DRAIN. cpu_hold and busy rise on the same edge.
- DRAIN: exactly 1 cycle, so the fetch read launched in the last RUN cycle completes. mem_addr holds the last cpu_addr. Next state is LOAD, and the pointer and ld_count clear to 0 on that edge.
- LOAD:
  - ld_ready=1 combinationally.
  - On ld_valid&ld_ready:
    - mem_we=1, mem_addr=pointer, mem_wdata=ld_data in the same cycle.
    - pointer and ld_count increment on the edge.
  - The block leaves for RELEASE on the edge where ld_done=1, or where the MAX_WORDS-th write occurs.
  - If ld_done and ld_valid are high in the same cycle, the word is written first, then the block exits.
  - The pointer never wraps. No write happens at address MAX_WORDS.
  - ld_start is ignored outside RUN.
- RELEASE:
  - cpu_rst=1 and cpu_hold=1 for exactly RST_CYCLES cycles.
  - ld_ready=0, mem_addr=cpu_addr, mem_we=0.
  - Then the block returns to RUN: cpu_rst=0, cpu_hold=0, busy=0 on the same edge.
- ld_count holds its value in RUN until the next load begins.
- cpu_instr = mem_rdata at all times. Its value is meaningless while cpu_hold=1.
- Reset mid-LOAD aborts immediately to RUN. Memory keeps a partial image, ld_count returns to 0, and no cpu_rst pulse is produced beyond the external reset itself.
- A load of zero words (ld_done already high on entry to LOAD) is legal: ld_count=0, and the RELEASE sequence still runs.

Optional Feature:
IMEM_LOAD_CHECKSUM_EN:
- Defined: ld_checksum is a running 32-bit modular sum of every accepted ld_data word. It clears when DRAIN exits and holds its value afterwards.
- Undefined: no adder is built and ld_checksum is tied to 0.

Decomposition:
- Package imem_arb_pkg holds:
  - the state enum (RUN=0, DRAIN=1, LOAD=2, RELEASE=3, 2 bits);
  - the default widths ADDR_W and DATA_W;
  - the RST_CYCLES default.
- One sub-module is natural: imem_rst_stretch, a loadable down-counter producing cpu_rst for N cycles with a done strobe.

Test Plan:
- Reset release, then cpu_addr=0x0005 → mem_addr=0x0005, mem_we=0, cpu_hold=0, busy=0.
- ld_start for 1 cycle in RUN → one DRAIN cycle, then ld_ready=1; cpu_hold=1 from the edge after ld_start.
- Stream 3 words 0x20080001, 0x20090002, 0x01095020 with gaps in ld_valid, then ld_done → writes at addresses 0, 1, 2 only; ld_count=3; cpu_rst=1 for exactly 4 cycles; then RUN.
- ld_valid and ld_done high on the same cycle with word 0xDEADBEEF as the 2nd word → both words written, ld_count=2.
- MAX_WORDS=8 build, stream 10 words without ld_done → 8 writes (addresses 0..7), exit to RELEASE, ld_ready=0 afterwards.
- Assert reset during LOAD after 2 words → RUN immediately, ld_count=0, cpu_hold=0, cpu_rst=0.
- With IMEM_LOAD_CHECKSUM_EN, load 0xFFFFFFFF and 0x00000002 → ld_checksum=0x00000001.
